mealy_stream_ctrl: RTL and testbench

- Sequencing controller for the serial Mealy pattern detector.
- Accepts parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per clock, into an internal Mealy detector.
- Counts pattern hits per word and returns the count over a second valid/ready handshake.
- Sits between a word-oriented producer and the bit-serial detection datapath, so the detector can be driven by bus-side logic instead of a hand-driven serial input.

---
 rtl/mealy_stream_ctrl_pkg.sv | 20 ++
 rtl/serial_pattern_mealy.sv | 54 +++++
 rtl/mealy_stream_ctrl.sv | 134 +++++++++++++
 tb/tb_mealy_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mealy_stream_ctrl_pkg
// Brief    : Shared state encoding and default pattern for the stream controller.
// Revision : 1.0 - initial release
// ============================================================================
package mealy_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int                        c_default_w       = 8;
  localparam int                        c_default_plen    = 4;
  localparam logic [c_default_plen-1:0] c_default_pattern = 4'b1011;

endpackage
`default_nettype wire

// File: rtl/serial_pattern_mealy.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_mealy
// Brief    : Bit-serial Mealy pattern matcher with history and fill tracking.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_mealy
  import mealy_stream_ctrl_pkg::*;
#(
  parameter int              PLEN    = c_default_plen,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(c_default_pattern)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic bit_in,
  output logic match
);

  generate
    if (PLEN == 1) begin : g_single
      assign match = en & (bit_in == PATTERN[0]);
    end else begin : g_multi
      localparam int c_hw = PLEN - 1;
      localparam int c_fw = $clog2(PLEN);

      logic [c_hw-1:0] r_hist;
      logic [c_fw-1:0] r_fill;
      logic            w_full;

      assign w_full = (r_fill == c_fw'(PLEN - 1));
      // Match uses the live bit plus the stored history (Mealy output).
      assign match  = en & w_full & ({r_hist, bit_in} == PATTERN);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_hist <= '0;
          r_fill <= '0;
        end else if (clr) begin
          r_hist <= '0;
          r_fill <= '0;
        end else if (en) begin
          r_hist <= c_hw'({r_hist, bit_in});
          if (!w_full) begin
            r_fill <= r_fill + 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mealy_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mealy_stream_ctrl
// Brief    : Word-in / count-out sequencer around the serial Mealy detector.
// Revision : 1.0 - initial release
// ============================================================================
module mealy_stream_ctrl
  import mealy_stream_ctrl_pkg::*;
#(
  parameter int              W       = c_default_w,
  parameter int              PLEN    = c_default_plen,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(c_default_pattern),
  parameter int              CW      = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_restart,
  output logic          bit_out,
  output logic          hit,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count
);

  localparam int c_iw = $clog2(W);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_shreg;
  logic [c_iw-1:0] r_idx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_out_count;
  logic            r_hit;
  logic            w_accept;
  logic            w_shift;
  logic            w_last;
  logic            w_bit;
  logic            w_match;
  logic [CW-1:0]   w_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_shift   = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (w_last) begin
          w_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_last     = (r_idx == c_iw'(W - 1));
  assign w_bit      = w_shift & r_shreg[W-1];
  assign w_cnt_next = r_cnt + CW'(w_match);

  serial_pattern_mealy #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk    (clk),
    .reset  (reset),
    .en     (w_shift),
    .clr    (w_accept & in_restart),
    .bit_in (w_bit),
    .match  (w_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_count <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_hit <= w_match;
      if (w_accept) begin
        r_shreg <= in_data;
        r_idx   <= '0;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[W-2:0], 1'b0};
        r_idx   <= r_idx + 1'b1;
        r_cnt   <= w_cnt_next;
        // Final count must include a match on the last bit of the word.
        if (w_last) begin
          r_out_count <= w_cnt_next;
        end
      end
    end
  end

  assign bit_out   = w_bit;
  assign hit       = r_hit;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_mealy_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mealy_stream_ctrl
// Brief    : Scoreboard bench for mealy_stream_ctrl with a bit-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mealy_stream_ctrl;

  localparam int              W    = 8;
  localparam int              PLEN = 4;
  localparam logic [PLEN-1:0] PAT  = 4'b1011;
  localparam int              CW   = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_restart = 1'b0;
  logic          bit_out;
  logic          hit;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  bit stream[$];
  int hit_cnt = 0;

  always #5 clk = ~clk;

  mealy_stream_ctrl #(.W(W), .PLEN(PLEN), .PATTERN(PAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_restart (in_restart),
    .bit_out    (bit_out),
    .hit        (hit),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the bit stream since the last restart, scanned window by window.
  function automatic int model_word(input logic [W-1:0] d, input bit rs);
    int n;
    bit ok;
    n = 0;
    if (rs) stream.delete();
    for (int i = W - 1; i >= 0; i--) begin
      stream.push_back(d[i]);
      if (stream.size() > PLEN) void'(stream.pop_front());
      if (stream.size() == PLEN) begin
        ok = 1'b1;
        for (int k = 0; k < PLEN; k++)
          if (stream[k] != PAT[PLEN-1-k]) ok = 1'b0;
        if (ok) n++;
      end
    end
    return n;
  endfunction

  // Monitor: every result handshake pops one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (hit) hit_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("out_count", 32'(out_count), e);
          check("hit_pulses", hit_cnt, e);
        end
        hit_cnt = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit rs, input bit jitter, output int edges);
    bit got;
    got = 1'b0;
    edges = 0;
    in_valid = 1'b1;
    in_data = d;
    in_restart = rs;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      #1;
      if (jitter) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      edges++;
      exp_q.push_back(model_word(d, rs));
      #1;
      in_valid = 1'b0;
      in_data = W'($urandom);
      in_restart = 1'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_count"}, 32'(out_count), 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_bit_out"}, bit_out, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat;
    int n;
    bit done;
    logic [CW-1:0] held;

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("post_rst");

    // Single hit and accept-to-result latency.
    out_ready = 1'b1;
    send(8'hB0, 1'b1, 1'b0, lat);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check("latency_edges", n, W);
    drain();

    // Overlapping matches, then history carried across words.
    send(8'hB6, 1'b1, 1'b0, lat);
    send(8'h05, 1'b1, 1'b0, lat);
    send(8'h80, 1'b0, 1'b0, lat);
    send(8'h80, 1'b1, 1'b0, lat);
    drain();

    // Back-pressure in REPORT with a pending producer word.
    out_ready = 1'b0;
    send(8'hB0, 1'b1, 1'b0, lat);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check("stall_reached_report", done, 1);
    held = out_count;
    check("stall_count", 32'(held), 1);
    in_valid = 1'b1;
    in_data = 8'hB6;
    in_restart = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_count", 32'(out_count), 32'(held));
      check("stall_in_ready", in_ready, 0);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    send(8'hB6, 1'b1, 1'b0, lat);
    check("accept_after_handshake", lat, 2);
    drain();

    // Asynchronous reset while bit 4 of a word is being shifted.
    send(8'hBB, 1'b1, 1'b0, lat);
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_hit", hit, 1);
    reset = 1'b1;
    exp_q.delete();
    stream.delete();
    hit_cnt = 0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'hB0, 1'b0, 1'b0, lat);
    drain();

    // Randomised words, restarts and consumer back-pressure.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if ($urandom_range(0, 3) == 0) d = {4'b1011, 4'($urandom)};
      send(d, ($urandom_range(0, 3) == 0), 1'b1, lat);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
